// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Results are registered with the ID of the requester that issued them.
module alu_arbiter #(
  parameter int unsigned VWIDTH = 32,
  parameter int unsigned IWIDTH = 11,
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [IWIDTH-1:0] req0_instr,
  input  logic [VWIDTH-1:0] req0_a,
  input  logic [VWIDTH-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [IWIDTH-1:0] req1_instr,
  input  logic [VWIDTH-1:0] req1_a,
  input  logic [VWIDTH-1:0] req1_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [VWIDTH-1:0] res_data,
  output logic              res_id
);

  localparam int unsigned SHW = 5;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  localparam logic [AWIDTH-1:0] OP_ADD  = AWIDTH'(0);
  localparam logic [AWIDTH-1:0] OP_SUB  = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] OP_SLL  = AWIDTH'(2);
  localparam logic [AWIDTH-1:0] OP_SLT  = AWIDTH'(3);
  localparam logic [AWIDTH-1:0] OP_SLTU = AWIDTH'(4);
  localparam logic [AWIDTH-1:0] OP_XOR  = AWIDTH'(5);
  localparam logic [AWIDTH-1:0] OP_SRL  = AWIDTH'(6);
  localparam logic [AWIDTH-1:0] OP_SRA  = AWIDTH'(7);
  localparam logic [AWIDTH-1:0] OP_OR   = AWIDTH'(8);
  localparam logic [AWIDTH-1:0] OP_AND  = AWIDTH'(9);

  typedef struct packed {
    logic [IWIDTH-1:0] instr;
    logic [VWIDTH-1:0] a;
    logic [VWIDTH-1:0] b;
  } req_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  logic              last_grant;
  logic              can_accept;
  logic              any_valid;
  logic              winner;
  logic              xfer;
  req_t              sel;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [AWIDTH-1:0] aluop;
  logic [SHW-1:0]    shamt;
  logic [VWIDTH-1:0] aluout;

  // Arbitration: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    can_accept = rst_n & ((state == EMPTY) | res_ready);
    winner     = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
    req0_ready = can_accept & req0_valid & ~winner;
    req1_ready = can_accept & req1_valid & winner;
    xfer       = req0_ready | req1_ready;
  end

  // Operand mux driven by the winner.
  always_comb begin
    sel = '{instr: req0_instr, a: req0_a, b: req0_b};
    if (winner) begin
      sel = '{instr: req1_instr, a: req1_a, b: req1_b};
    end
  end

  // ALU controller: R/I-type decode; every other opcode performs ADD.
  always_comb begin
    opcode   = sel.instr[6:0];
    funct3   = sel.instr[9:7];
    funct7b5 = sel.instr[10];
    aluop    = OP_ADD;
    if ((opcode == OPC_RTYPE) || (opcode == OPC_ITYPE)) begin
      case (funct3)
        3'b000:  aluop = ((opcode == OPC_RTYPE) && funct7b5) ? OP_SUB : OP_ADD;
        3'b001:  aluop = OP_SLL;
        3'b010:  aluop = OP_SLT;
        3'b011:  aluop = OP_SLTU;
        3'b100:  aluop = OP_XOR;
        3'b101:  aluop = funct7b5 ? OP_SRA : OP_SRL;
        3'b110:  aluop = OP_OR;
        default: aluop = OP_AND;
      endcase
    end
  end

  // ALU datapath, wrap-around arithmetic, no flags.
  always_comb begin
    shamt  = sel.b[SHW-1:0];
    aluout = '0;
    case (aluop)
      OP_ADD:  aluout = VWIDTH'(sel.a + sel.b);
      OP_SUB:  aluout = VWIDTH'(sel.a - sel.b);
      OP_SLL:  aluout = VWIDTH'(sel.a << shamt);
      OP_SLT:  aluout = VWIDTH'(($signed(sel.a) < $signed(sel.b)) ? 1 : 0);
      OP_SLTU: aluout = VWIDTH'((sel.a < sel.b) ? 1 : 0);
      OP_XOR:  aluout = sel.a ^ sel.b;
      OP_SRL:  aluout = VWIDTH'(sel.a >> shamt);
      OP_SRA:  aluout = VWIDTH'($signed(sel.a) >>> shamt);
      OP_OR:   aluout = sel.a | sel.b;
      OP_AND:  aluout = sel.a & sel.b;
      default: aluout = VWIDTH'(sel.a + sel.b);
    endcase
  end

  // Output register FSM; a transfer refills even while the old result drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (xfer) begin
            state      <= FULL;
            res_valid  <= 1'b1;
            res_data   <= aluout;
            res_id     <= winner;
            last_grant <= winner;
          end
        end
        default: begin
          if (xfer) begin
            res_data   <= aluout;
            res_id     <= winner;
            last_grant <= winner;
          end else if (res_ready) begin
            state     <= EMPTY;
            res_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
